muldiv_unit: RTL

- Iterative multiply/divide unit in the execute stage, directly downstream of the register file read ports.
- Consumes rd1/rd2 as srca/srcb for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers. Their contents return to the register file write port (wd3) through the MFHI/MFLO path.
- Also accepts MTHI/MTLO writes and reports busy so control can stall dependent instructions.

---
 rtl/muldiv_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit holding the HI/LO registers.
// Takes one setup edge, WIDTH step edges and one finish edge per operation; MTHI/MTLO land while idle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINISH = 2'd2} state_t;

  state_t               state_r, state_nxt_s;
  logic [1:0]           op_r, op_nxt_s;
  logic                 sign_a_r, sign_a_nxt_s, sign_b_r, sign_b_nxt_s;
  logic                 divz_r, divz_nxt_s;
  logic [WIDTH-1:0]     srca_r, srca_nxt_s;
  logic [WIDTH-1:0]     opnd_r, opnd_nxt_s;
  logic [2*WIDTH-1:0]   acc_r, acc_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0]     hi_r, hi_nxt_s, lo_r, lo_nxt_s;
  logic                 busy_r, busy_nxt_s, done_r, done_nxt_s;

  logic                 in_sign_a_s, in_sign_b_s;
  logic [WIDTH-1:0]     in_mag_a_s, in_mag_b_s;
  logic [WIDTH:0]       mul_sum_s, div_trial_s;
  logic [2*WIDTH-1:0]   mul_step_s, div_step_s, prod_s;
  logic [WIDTH-1:0]     quot_s, rem_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt_s = RUN; else state_nxt_s = IDLE;
      RUN:     if (cnt_r == LAST_CNT) state_nxt_s = FINISH; else state_nxt_s = RUN;
      FINISH:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand magnitudes, one radix-2 step, and sign-corrected results
  always_comb begin
    in_sign_a_s = ~op[0] & srca[WIDTH-1];
    in_sign_b_s = ~op[0] & srcb[WIDTH-1];
    if (in_sign_a_s) in_mag_a_s = -srca; else in_mag_a_s = srca;
    if (in_sign_b_s) in_mag_b_s = -srcb; else in_mag_b_s = srcb;

    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    mul_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};

    // Trial subtraction of the divisor from the shifted partial remainder
    div_trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]} - {1'b0, opnd_r};
    if (!div_trial_s[WIDTH]) div_step_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    else                     div_step_s = {acc_r[2*WIDTH-2:0], 1'b0};

    if (~op_r[0] && (sign_a_r ^ sign_b_r)) prod_s = -acc_r; else prod_s = acc_r;
    if (~op_r[0] && (sign_a_r ^ sign_b_r)) quot_s = -acc_r[WIDTH-1:0]; else quot_s = acc_r[WIDTH-1:0];
    if (~op_r[0] && sign_a_r) rem_s = -acc_r[2*WIDTH-1:WIDTH]; else rem_s = acc_r[2*WIDTH-1:WIDTH];
  end

  // Datapath and output next values
  always_comb begin
    op_nxt_s     = op_r;
    sign_a_nxt_s = sign_a_r;
    sign_b_nxt_s = sign_b_r;
    divz_nxt_s   = divz_r;
    srca_nxt_s   = srca_r;
    opnd_nxt_s   = opnd_r;
    acc_nxt_s    = acc_r;
    cnt_nxt_s    = cnt_r;
    hi_nxt_s     = hi_r;
    lo_nxt_s     = lo_r;
    busy_nxt_s   = busy_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (hi_we) hi_nxt_s = wd; else hi_nxt_s = hi_r;
        if (lo_we) lo_nxt_s = wd; else lo_nxt_s = lo_r;
        if (start) begin
          op_nxt_s     = op;
          sign_a_nxt_s = in_sign_a_s;
          sign_b_nxt_s = in_sign_b_s;
          divz_nxt_s   = (srcb == {WIDTH{1'b0}});
          srca_nxt_s   = srca;
          cnt_nxt_s    = {CW{1'b0}};
          busy_nxt_s   = 1'b1;
          if (op[1]) begin
            opnd_nxt_s = in_mag_b_s;
            acc_nxt_s  = {{WIDTH{1'b0}}, in_mag_a_s};
          end else begin
            opnd_nxt_s = in_mag_a_s;
            acc_nxt_s  = {{WIDTH{1'b0}}, in_mag_b_s};
          end
        end else begin
          busy_nxt_s = 1'b0;
        end
      end
      RUN: begin
        if (op_r[1]) acc_nxt_s = div_step_s; else acc_nxt_s = mul_step_s;
        cnt_nxt_s = cnt_r + 1'b1;
      end
      FINISH: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b1;
        if (!op_r[1]) begin
          hi_nxt_s = prod_s[2*WIDTH-1:WIDTH];
          lo_nxt_s = prod_s[WIDTH-1:0];
        end else if (divz_r) begin
          hi_nxt_s = srca_r;
          lo_nxt_s = {WIDTH{1'b1}};
        end else begin
          hi_nxt_s = rem_s;
          lo_nxt_s = quot_s;
        end
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r     <= 2'b00;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      divz_r   <= 1'b0;
      srca_r   <= {WIDTH{1'b0}};
      opnd_r   <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CW{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      op_r     <= op_nxt_s;
      sign_a_r <= sign_a_nxt_s;
      sign_b_r <= sign_b_nxt_s;
      divz_r   <= divz_nxt_s;
      srca_r   <= srca_nxt_s;
      opnd_r   <= opnd_nxt_s;
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      hi_r     <= hi_nxt_s;
      lo_r     <= lo_nxt_s;
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
